// File: rtl/data_ram_if.sv
// One access port of the data RAM: byte write enables, word address, write data and
// registered read data. The caller drives the master side.
interface data_ram_if;
  logic [3:0]  we;
  logic [29:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output we, addr, din, input dout);
  modport slave  (input we, addr, din, output dout);
endinterface

// File: rtl/data_ram.sv
// True dual-port word RAM with per-byte write enables and read-first registered outputs.
// Port A is the CPU load/store path, port B the debug/host port.
module data_ram #(
  parameter int unsigned ADDR_LEN = 12
) (
  input logic        clk,
  input logic        rst,
  data_ram_if.slave  a_io,
  data_ram_if.slave  b_io
);

  localparam int unsigned Depth = 2 ** ADDR_LEN;

  logic [31:0]         mem_q [Depth];
  logic [31:0]         douta_q, doutb_q;
  logic [ADDR_LEN-1:0] idx_a, idx_b;
  logic                unused_addr;

  // Upper address bits are ignored, so the array aliases every Depth words.
  assign idx_a       = a_io.addr[ADDR_LEN-1:0];
  assign idx_b       = b_io.addr[ADDR_LEN-1:0];
  assign unused_addr = ^{a_io.addr[29:ADDR_LEN], b_io.addr[29:ADDR_LEN]};

  // Port A lanes are written last so they win a same-word, same-lane collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (b_io.we[i]) mem_q[idx_b][8*i +: 8] <= b_io.din[8*i +: 8];
      end
      for (int i = 0; i < 4; i++) begin
        if (a_io.we[i]) mem_q[idx_a][8*i +: 8] <= a_io.din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= mem_q[idx_a];
      doutb_q <= mem_q[idx_b];
    end
  end

  assign a_io.dout = douta_q;
  assign b_io.dout = doutb_q;

endmodule

// File: tb/tb_data_ram.sv
// Randomised bench for data_ram against a word-array reference model, with directed
// literal checks for the write, byte-lane, read-first, collision, alias and reset cases.
module tb_data_ram;

  localparam int unsigned AddrLen = 12;
  localparam int unsigned Words   = 2 ** AddrLen;

  logic clk;
  logic rst;

  data_ram_if a_if ();
  data_ram_if b_if ();

  data_ram #(.ADDR_LEN(AddrLen)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_io (a_if),
    .b_io (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [31:0] model [Words];
  logic [31:0] exp_a, exp_b;
  logic        chk_en;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Rising-edge behaviour: read-first on both ports, lane-wise writes with A over B.
  task automatic model_edge();
    int ia, ib;
    ia = int'(a_if.addr) % Words;
    ib = int'(b_if.addr) % Words;
    if (rst) begin
      exp_a = 32'h0;
      exp_b = 32'h0;
    end else begin
      exp_a = model[ia];
      exp_b = model[ib];
      for (int i = 0; i < 4; i++)
        if (b_if.we[i]) model[ib][8*i +: 8] = b_if.din[8*i +: 8];
      for (int i = 0; i < 4; i++)
        if (a_if.we[i]) model[ia][8*i +: 8] = a_if.din[8*i +: 8];
    end
  endtask

  // One clock: inputs set before this are sampled, model advances, then #1 for new inputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [3:0] wa, input logic [29:0] aa, input logic [31:0] da,
                       input logic [3:0] wb, input logic [29:0] ab, input logic [31:0] db);
    a_if.we = wa; a_if.addr = aa; a_if.din = da;
    b_if.we = wb; b_if.addr = ab; b_if.din = db;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("douta", a_if.dout, exp_a);
      check("doutb", b_if.dout, exp_b);
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    exp_a  = 32'h0;
    exp_b  = 32'h0;
    for (int i = 0; i < Words; i++) model[i] = 32'h0;
    drive(4'h0, 30'd0, 32'h0, 4'h0, 30'd0, 32'h0);
    rst = 1'b1;
    #1;
    check("reset_douta", a_if.dout, 32'h0);
    check("reset_doutb", b_if.dout, 32'h0);
    step();
    step();
    rst = 1'b0;

    // Clear the array so the bench does not depend on simulator power-up values.
    for (int i = 0; i < Words / 2; i++) begin
      drive(4'hF, 30'(2 * i), 32'h0, 4'hF, 30'(2 * i + 1), 32'h0);
      step();
    end
    drive(4'h0, 30'd0, 32'h0, 4'h0, 30'd0, 32'h0);
    step();
    chk_en = 1'b1;

    // Full-word write then read on both ports.
    drive(4'hF, 30'd5, 32'hDEADBEEF, 4'h0, 30'd0, 32'h0);
    step();
    drive(4'h0, 30'd5, 32'h0, 4'h0, 30'd5, 32'h0);
    step();
    check("full_word_a", a_if.dout, 32'hDEADBEEF);
    check("full_word_b", b_if.dout, 32'hDEADBEEF);
    check("model_full_word", exp_a, 32'hDEADBEEF);

    // Byte lanes.
    drive(4'b0100, 30'd5, 32'h00AA0000, 4'h0, 30'd5, 32'h0);
    step();
    drive(4'h0, 30'd5, 32'h0, 4'h0, 30'd5, 32'h0);
    step();
    check("lane2", a_if.dout, 32'hDEAABEEF);
    drive(4'b0011, 30'd5, 32'h00001234, 4'h0, 30'd5, 32'h0);
    step();
    drive(4'h0, 30'd5, 32'h0, 4'h0, 30'd5, 32'h0);
    step();
    check("lane10", a_if.dout, 32'hDEAA1234);
    check("model_lane10", exp_a, 32'hDEAA1234);

    // Read-first on the writing port.
    drive(4'hF, 30'd7, 32'h11111111, 4'h0, 30'd0, 32'h0);
    step();
    check("read_first_old", a_if.dout, 32'h0);
    drive(4'h0, 30'd7, 32'h0, 4'h0, 30'd0, 32'h0);
    step();
    check("read_first_new", a_if.dout, 32'h11111111);

    // Same-word collision, lane 1 enabled on both ports.
    drive(4'b0011, 30'd9, 32'hAAAAAAAA, 4'b0110, 30'd9, 32'hBBBBBBBB);
    step();
    check("collide_old_b", b_if.dout, 32'h0);
    drive(4'h0, 30'd9, 32'h0, 4'h0, 30'd9, 32'h0);
    step();
    check("collision", a_if.dout, 32'h00BBAAAA);
    check("model_collision", exp_b, 32'h00BBAAAA);

    // Aliasing above the decoded range.
    drive(4'hF, 30'(Words + 3), 32'h5A5A5A5A, 4'h0, 30'd0, 32'h0);
    step();
    drive(4'h0, 30'd0, 32'h0, 4'h0, 30'd3, 32'h0);
    step();
    check("alias", b_if.dout, 32'h5A5A5A5A);

    // Async reset after reading a nonzero word; a write during reset is dropped.
    drive(4'h0, 30'd5, 32'h0, 4'h0, 30'd9, 32'h0);
    step();
    check("pre_reset", a_if.dout, 32'hDEAA1234);
    rst   = 1'b1;
    exp_a = 32'h0;
    exp_b = 32'h0;
    #1;
    check("async_rst_a", a_if.dout, 32'h0);
    check("async_rst_b", b_if.dout, 32'h0);
    drive(4'hF, 30'd5, 32'hFFFFFFFF, 4'hF, 30'd9, 32'hFFFFFFFF);
    step();
    step();
    rst = 1'b0;
    drive(4'h0, 30'd5, 32'h0, 4'h0, 30'd9, 32'h0);
    step();
    check("post_reset_a", a_if.dout, 32'hDEAA1234);
    check("post_reset_b", b_if.dout, 32'h00BBAAAA);

    // Random traffic over a small aliased window to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      drive(4'($urandom_range(0, 15)),
            30'($urandom_range(0, 15) + Words * $urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)),
            30'($urandom_range(0, 15) + Words * $urandom_range(0, 3)), $urandom);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst   = 1'b1;
        exp_a = 32'h0;
        exp_b = 32'h0;
      end
      step();
    end
    rst = 1'b0;
    drive(4'h0, 30'd0, 32'h0, 4'h0, 30'd0, 32'h0);
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
